b_regfile_xfer: RTL

- Parametrised secondary (B) address register file with a built-in block-transfer sequencer.
- Provides one registered jk read port, one scalar write port and return-jump capture of P into B00.
- Adds autonomous block load (memory -> B) and block store (B -> memory) over valid/ready streams toward the memory port.
- Starting index and word count come from the issue stage; the index wraps modulo DEPTH.

---
 rtl/b_regfile_xfer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/b_regfile_xfer.sv
// B address register file with one registered read port, one scalar write port,
// return-jump capture into B00, and a block load/store sequencer that streams
// words between the file and memory over valid/ready handshakes.
module b_regfile_xfer #(
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned LOGDEPTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LOGDEPTH-1:0] i_jk_addr,
    output logic [WIDTH-1:0]    o_jk_data,
    input  logic [LOGDEPTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]    i_wr_data,
    input  logic                i_wr_en,
    input  logic [WIDTH-1:0]    i_cur_p,
    input  logic                i_rtn_jump,
    input  logic                i_blk_start,
    input  logic                i_blk_dir,
    input  logic [LOGDEPTH-1:0] i_blk_first,
    input  logic [LOGDEPTH:0]   i_blk_len,
    input  logic [WIDTH-1:0]    i_ld_data,
    input  logic                i_ld_valid,
    output logic                o_ld_ready,
    output logic [WIDTH-1:0]    o_st_data,
    output logic                o_st_valid,
    input  logic                i_st_ready,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_wr_drop
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [1:0]          state_q, state_d;
    logic [LOGDEPTH-1:0] idx_q, idx_d;
    logic [LOGDEPTH:0]   cnt_q, cnt_d;     // LOAD: words left; STORE: reads left to issue
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [WIDTH-1:0]    skid0_q, skid1_q; // skid0 is the stream head
    logic                busy;
    logic                ld_accept;
    logic                st_pop;
    logic                rd_issue;
    logic [WIDTH-1:0]    rd_word;

    assign busy       = (state_q == LOAD) || (state_q == STORE);
    assign o_busy     = busy;
    assign o_done     = (state_q == DONE);
    assign o_ld_ready = (state_q == LOAD) && !i_rtn_jump;
    assign ld_accept  = o_ld_ready && i_ld_valid;
    assign o_st_valid = (fifo_cnt_q != 2'd0);
    assign o_st_data  = skid0_q;
    assign st_pop     = o_st_valid && i_st_ready;
    // Only prefetch when the skid buffer will have room after this cycle's pop.
    assign rd_issue   = (state_q == STORE) && (cnt_q != '0) &&
                        ((fifo_cnt_q != 2'd2) || st_pop);
    assign rd_word    = mem[idx_q];

    // Skid-buffer occupancy after this cycle's push/pop.
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (rd_issue && !st_pop) begin
            fifo_cnt_d = fifo_cnt_q + 2'd1;
        end else if (!rd_issue && st_pop) begin
            fifo_cnt_d = fifo_cnt_q - 2'd1;
        end
    end

    // Sequencer next state, index and count.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_blk_start) begin
                    idx_d = i_blk_first;
                    cnt_d = i_blk_len;
                    if (i_blk_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = i_blk_dir ? STORE : LOAD;
                    end
                end
            end
            LOAD: begin
                if (ld_accept) begin
                    idx_d = idx_q + LOGDEPTH'(1);
                    cnt_d = cnt_q - (LOGDEPTH + 1)'(1);
                    if (cnt_q == (LOGDEPTH + 1)'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            STORE: begin
                if (rd_issue) begin
                    idx_d = idx_q + LOGDEPTH'(1);
                    cnt_d = cnt_q - (LOGDEPTH + 1)'(1);
                end
                if ((cnt_d == '0) && (fifo_cnt_d == 2'd0)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            fifo_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Skid buffer: shift toward the head on pop, append prefetched word on issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid0_q <= '0;
            skid1_q <= '0;
        end else if (st_pop) begin
            if (fifo_cnt_q == 2'd2) begin
                skid0_q <= skid1_q;
                if (rd_issue) begin
                    skid1_q <= rd_word;
                end
            end else begin
                skid0_q <= rd_word;
            end
        end else if (rd_issue) begin
            if (fifo_cnt_q == 2'd0) begin
                skid0_q <= rd_word;
            end else begin
                skid1_q <= rd_word;
            end
        end
    end

    // Array write: return jump beats block load beats scalar write. Not reset.
    always_ff @(posedge clk) begin
        if (i_rtn_jump) begin
            mem[0] <= i_cur_p;
        end else if (ld_accept) begin
            mem[idx_q] <= i_ld_data;
        end else if (i_wr_en && !busy) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port and dropped-write flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_jk_data <= '0;
            o_wr_drop <= 1'b0;
        end else begin
            o_jk_data <= mem[i_jk_addr];
            o_wr_drop <= i_wr_en && (busy || i_rtn_jump);
        end
    end

endmodule
